mtm_alu_deserializer: RTL and testbench

Serial input stage of the mtm_Alu. Samples `sin` one bit per clock, reassembles 11-bit byte frames into a packet of eight DATA bytes plus one CTL byte, and checks packet length, CRC4 and opcode. Presents operands B, A and the opcode to the ALU core with a one-cycle valid strobe, or raises exactly one error strobe, which the output serializer turns into an error response.

---
 rtl/mtm_alu_deserializer.sv | 160 ++++++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_deserializer.sv
// Serial input stage of the mtm_Alu: reassembles 11-bit frames into a
// packet of eight DATA bytes plus one CTL byte, validates length, CRC4 and
// opcode, and emits either a one-cycle valid strobe or one error strobe.
module mtm_alu_deserializer #(
  parameter logic [3:0] CRC_INIT = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic        valid,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        type_q, type_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        frame_done;
  logic        frame_err;

  logic [63:0] data_q;
  logic [3:0]  count_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic        valid_q, err_data_q, err_crc_q, err_op_q;

  logic [2:0]  ctl_op;
  logic [3:0]  ctl_crc;
  logic [3:0]  crc_calc;
  logic        op_legal;

  // Bit-serial CRC4 (x^4+x+1), MSB first; evaluated in parallel when the
  // CTL byte arrives, so no running CRC state has to be carried.
  function automatic logic [3:0] crc4(input logic [67:0] msg, input logic [3:0] seed);
    logic [3:0] c;
    logic       fb;
    c = seed;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign ctl_op   = byte_q[6:4];
  assign ctl_crc  = byte_q[3:0];
  assign crc_calc = crc4({data_q, 1'b1, ctl_op}, CRC_INIT);
  assign op_legal = (ctl_op == 3'b000) || (ctl_op == 3'b001) ||
                    (ctl_op == 3'b100) || (ctl_op == 3'b101);

  // Byte FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      type_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
      byte_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
    end
  end

  // Byte FSM next state: start -> type -> 8 payload bits -> stop check
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    bit_cnt_d  = bit_cnt_q;
    byte_d     = byte_q;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!sin) state_d = S_TYPE;
      end
      S_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
        state_d   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        byte_d    = {byte_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (sin) frame_done = 1'b1;
        else     frame_err  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Packet assembly, checks in priority order, and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= 64'd0;
      count_q    <= 4'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 3'd0;
      valid_q    <= 1'b0;
      err_data_q <= 1'b0;
      err_crc_q  <= 1'b0;
      err_op_q   <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      err_data_q <= 1'b0;
      err_crc_q  <= 1'b0;
      err_op_q   <= 1'b0;
      if (frame_err) begin
        err_data_q <= 1'b1;
        count_q    <= 4'd0;
      end else if (frame_done) begin
        if (!type_q) begin
          data_q  <= {data_q[55:0], byte_q};
          count_q <= (count_q == 4'd9) ? 4'd9 : count_q + 4'd1;
        end else begin
          count_q <= 4'd0;
          if (count_q != 4'd8) begin
            err_data_q <= 1'b1;
          end else if (ctl_crc != crc_calc) begin
            err_crc_q <= 1'b1;
          end else if (!op_legal) begin
            err_op_q <= 1'b1;
          end else begin
            valid_q <= 1'b1;
            b_q     <= data_q[63:32];
            a_q     <= data_q[31:0];
            op_q    <= ctl_op;
          end
        end
      end
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign op       = op_q;
  assign valid    = valid_q;
  assign err_data = err_data_q;
  assign err_crc  = err_crc_q;
  assign err_op   = err_op_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for the mtm_Alu serial deserializer.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic [31:0] A, B;
  logic [2:0]  op;
  logic        valid, err_data, err_crc, err_op;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_ed = 0, n_ec = 0, n_eo = 0;

  logic [31:0] exp_a = 32'd0, exp_b = 32'd0;
  logic [2:0]  exp_op = 3'd0;

  always #5 clk = ~clk;

  mtm_alu_deserializer dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .A(A), .B(B), .op(op),
    .valid(valid), .err_data(err_data), .err_crc(err_crc), .err_op(err_op)
  );

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (valid)    n_valid++;
    if (err_data) n_ed++;
    if (err_crc)  n_ec++;
    if (err_op)   n_eo++;
  end

  // CRC as polynomial long division of msg*x^4 by 10011 (zero seed)
  function automatic logic [3:0] crc_div(input logic [67:0] msg);
    logic [71:0] v;
    v = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction

  function automatic logic [3:0] good_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o);
    return crc_div({b, a, 1'b1, o});
  endfunction

  // Drives one 11-bit frame; returns 1 time unit after the stop bit's edge
  task automatic send_frame(input logic typ, input logic [7:0] pay, input logic stop_bit);
    logic [10:0] f;
    f = {1'b0, typ, pay, stop_bit};
    for (int i = 10; i >= 0; i--) begin
      sin = f[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o,
                             input logic [3:0] c, input int ndata);
    logic [63:0] d;
    logic [7:0]  by;
    d = {b, a};
    for (int k = 0; k < ndata; k++) begin
      by = (k < 8) ? d[63 - 8*k -: 8] : 8'hA5;
      send_frame(1'b0, by, 1'b1);
    end
    send_frame(1'b1, {1'b0, o, c}, 1'b1);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (A !== 32'd0)  begin errors++; $display("FAIL reset_A got=%h exp=0", A); end
    checks++; if (B !== 32'd0)  begin errors++; $display("FAIL reset_B got=%h exp=0", B); end
    checks++; if (op !== 3'd0)  begin errors++; $display("FAIL reset_op got=%b exp=000", op); end
    checks++; if ({valid, err_data, err_crc, err_op} !== 4'b0000)
      begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {valid, err_data, err_crc, err_op}); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_valid_add;
    int v0, e0;
    v0 = n_valid; e0 = n_ed + n_ec + n_eo;
    send_packet(32'd7, 32'd3, 3'b100, good_crc(32'd7, 32'd3, 3'b100), 8);
    exp_a = 32'd3; exp_b = 32'd7; exp_op = 3'b100;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", valid); end
    checks++; if (A !== exp_a || B !== exp_b || op !== exp_op)
      begin errors++; $display("FAIL add_ops got A=%h B=%h op=%b exp A=%h B=%h op=%b", A, B, op, exp_a, exp_b, exp_op); end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL add_pulse_width got=%b exp=0", valid); end
    checks++; if (n_valid - v0 != 1 || n_ed + n_ec + n_eo - e0 != 0)
      begin errors++; $display("FAIL add_counts valid=%0d errs=%0d exp 1/0", n_valid - v0, n_ed + n_ec + n_eo - e0); end
    $display("valid ADD: A=%h B=%h op=%b", A, B, op);
  endtask

  task automatic test_short_packet;
    int v0, d0;
    v0 = n_valid; d0 = n_ed;
    send_packet(32'h11223344, 32'h0, 3'b100, 4'h0, 3);
    checks++; if (err_data !== 1'b1 || valid !== 1'b0 || err_crc !== 1'b0 || err_op !== 1'b0)
      begin errors++; $display("FAIL short_strobes got v/d/c/o=%b%b%b%b exp=0100", valid, err_data, err_crc, err_op); end
    checks++; if (A !== exp_a || B !== exp_b || op !== exp_op)
      begin errors++; $display("FAIL short_retain got A=%h B=%h op=%b", A, B, op); end
    send_packet(32'hDEADBEEF, 32'h12345678, 3'b101, good_crc(32'hDEADBEEF, 32'h12345678, 3'b101), 8);
    exp_a = 32'h12345678; exp_b = 32'hDEADBEEF; exp_op = 3'b101;
    checks++; if (valid !== 1'b1 || A !== exp_a || B !== exp_b || op !== exp_op)
      begin errors++; $display("FAIL short_recover got v=%b A=%h B=%h op=%b", valid, A, B, op); end
    @(posedge clk); #1;
    checks++; if (n_valid - v0 != 1 || n_ed - d0 != 1)
      begin errors++; $display("FAIL short_counts valid=%0d err_data=%0d exp 1/1", n_valid - v0, n_ed - d0); end
    $display("short packet then recovery: A=%h B=%h", A, B);
  endtask

  task automatic test_crc_error;
    int v0, d0, c0, o0;
    v0 = n_valid; d0 = n_ed; c0 = n_ec; o0 = n_eo;
    send_packet(32'd7, 32'd3, 3'b100, 4'h0, 8);
    checks++; if (err_crc !== 1'b1 || valid !== 1'b0 || err_data !== 1'b0 || err_op !== 1'b0)
      begin errors++; $display("FAIL crc_strobes got v/d/c/o=%b%b%b%b exp=0010", valid, err_data, err_crc, err_op); end
    checks++; if (A !== exp_a || B !== exp_b || op !== exp_op)
      begin errors++; $display("FAIL crc_retain got A=%h B=%h op=%b", A, B, op); end
    send_packet(32'd7, 32'd3, 3'b100, 4'h0, 9);
    checks++; if (err_data !== 1'b1 || err_crc !== 1'b0 || valid !== 1'b0 || err_op !== 1'b0)
      begin errors++; $display("FAIL crc_priority got v/d/c/o=%b%b%b%b exp=0100", valid, err_data, err_crc, err_op); end
    @(posedge clk); #1;
    checks++; if (n_valid - v0 != 0 || n_ed - d0 != 1 || n_ec - c0 != 1 || n_eo - o0 != 0)
      begin errors++; $display("FAIL crc_counts v=%0d d=%0d c=%0d o=%0d exp 0/1/1/0", n_valid - v0, n_ed - d0, n_ec - c0, n_eo - o0); end
    $display("crc error and 9-byte priority done");
  endtask

  task automatic test_bad_opcode;
    int o0, v0;
    o0 = n_eo; v0 = n_valid;
    send_packet(32'd7, 32'd3, 3'b010, good_crc(32'd7, 32'd3, 3'b010), 8);
    checks++; if (err_op !== 1'b1 || valid !== 1'b0 || err_data !== 1'b0 || err_crc !== 1'b0)
      begin errors++; $display("FAIL op_strobes got v/d/c/o=%b%b%b%b exp=0001", valid, err_data, err_crc, err_op); end
    checks++; if (A !== exp_a || B !== exp_b || op !== exp_op)
      begin errors++; $display("FAIL op_retain got A=%h B=%h op=%b", A, B, op); end
    @(posedge clk); #1;
    checks++; if (n_eo - o0 != 1 || n_valid - v0 != 0)
      begin errors++; $display("FAIL op_counts err_op=%0d valid=%0d exp 1/0", n_eo - o0, n_valid - v0); end
    $display("undefined opcode 010 rejected");
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    logic [31:0] val;
    int v0, e0;
    v0 = n_valid; e0 = n_ed + n_ec + n_eo;
    for (int k = 0; k < 8; k++) begin
      val = (k < 4) ? 32'hFFFFFFFF : 32'h00000000;
      send_packet(val, val, ops[k % 4], good_crc(val, val, ops[k % 4]), 8);
      checks++; if (valid !== 1'b1 || A !== val || B !== val || op !== ops[k % 4])
        begin errors++; $display("FAIL extreme_%0d got v=%b A=%h B=%h op=%b exp A=B=%h op=%b", k, valid, A, B, op, val, ops[k % 4]); end
      $display("extreme packet %0d: A=%h B=%h op=%b", k, A, B, op);
    end
    exp_a = 32'h0; exp_b = 32'h0; exp_op = 3'b101;
    @(posedge clk); #1;
    checks++; if (n_valid - v0 != 8 || n_ed + n_ec + n_eo - e0 != 0)
      begin errors++; $display("FAIL extreme_counts valid=%0d errs=%0d exp 8/0", n_valid - v0, n_ed + n_ec + n_eo - e0); end
  endtask

  task automatic test_reset_midframe;
    logic [63:0] d;
    int v0, e0;
    // load nonzero outputs first so the reset is observable
    send_packet(32'hCAFEF00D, 32'h0BADC0DE, 3'b001, good_crc(32'hCAFEF00D, 32'h0BADC0DE, 3'b001), 8);
    exp_a = 32'h0BADC0DE; exp_b = 32'hCAFEF00D; exp_op = 3'b001;
    d = {32'h55AA55AA, 32'h01020304};
    for (int k = 0; k < 4; k++) send_frame(1'b0, d[63 - 8*k -: 8], 1'b1);
    sin = 1'b0; @(posedge clk); #1;   // start
    sin = 1'b0; @(posedge clk); #1;   // type
    for (int i = 0; i < 4; i++) begin sin = i[0]; @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (A !== 32'd0 || B !== 32'd0 || op !== 3'd0)
      begin errors++; $display("FAIL midreset_outputs got A=%h B=%h op=%b exp 0", A, B, op); end
    sin = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    v0 = n_valid; e0 = n_ed + n_ec + n_eo;
    send_packet(32'h00000010, 32'h00000020, 3'b000, good_crc(32'h10, 32'h20, 3'b000), 8);
    checks++; if (valid !== 1'b1 || A !== 32'h20 || B !== 32'h10 || op !== 3'b000)
      begin errors++; $display("FAIL midreset_packet got v=%b A=%h B=%h op=%b", valid, A, B, op); end
    @(posedge clk); #1;
    checks++; if (n_valid - v0 != 1 || n_ed + n_ec + n_eo - e0 != 0)
      begin errors++; $display("FAIL midreset_counts valid=%0d errs=%0d exp 1/0", n_valid - v0, n_ed + n_ec + n_eo - e0); end
    exp_a = 32'h20; exp_b = 32'h10; exp_op = 3'b000;
    $display("reset mid-frame then packet: A=%h B=%h", A, B);
  endtask

  task automatic test_framing_error;
    int v0, d0;
    v0 = n_valid; d0 = n_ed;
    send_frame(1'b0, 8'h77, 1'b1);
    send_frame(1'b0, 8'h66, 1'b0);
    sin = 1'b1;
    checks++; if (err_data !== 1'b1 || valid !== 1'b0)
      begin errors++; $display("FAIL framing_strobe got err_data=%b valid=%b exp 1/0", err_data, valid); end
    @(posedge clk); #1;
    checks++; if (err_data !== 1'b0)
      begin errors++; $display("FAIL framing_pulse_width got=%b exp=0", err_data); end
    checks++; if (A !== exp_a || B !== exp_b || op !== exp_op)
      begin errors++; $display("FAIL framing_retain got A=%h B=%h op=%b", A, B, op); end
    send_packet(32'h89ABCDEF, 32'h76543210, 3'b100, good_crc(32'h89ABCDEF, 32'h76543210, 3'b100), 8);
    checks++; if (valid !== 1'b1 || A !== 32'h76543210 || B !== 32'h89ABCDEF || op !== 3'b100)
      begin errors++; $display("FAIL framing_recover got v=%b A=%h B=%h op=%b", valid, A, B, op); end
    @(posedge clk); #1;
    checks++; if (n_valid - v0 != 1 || n_ed - d0 != 1)
      begin errors++; $display("FAIL framing_counts valid=%0d err_data=%0d exp 1/1", n_valid - v0, n_ed - d0); end
    $display("framing error then recovery: A=%h B=%h", A, B);
  endtask

  initial begin
    test_reset;
    test_valid_add;
    test_short_packet;
    test_crc_error;
    test_bad_opcode;
    test_back_to_back;
    test_reset_midframe;
    test_framing_error;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
